// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the two-channel input debouncer.
package input_debouncer_pkg;

  // Per-channel FSM encoding.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce channel: synchronizer chain, stability FSM, counter and edge strobes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STABLE | synchronized input agrees with q, counter held at 0
// ST_COUNT  | synchronized input disagrees with q, counting agreement run
module input_debouncer_channel
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CW-1:0]          cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Stability FSM; q toggles only after STABLE_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (s != q) begin
            if (STABLE_CYCLES == 1) begin
              q    <= s;
              rise <= s;
              fall <= ~s;
              cnt  <= '0;
            end else begin
              state <= ST_COUNT;
              cnt   <= CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNT: begin
          if (s == q) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            q     <= s;
            rise  <= s;
            fall  <= ~s;
            cnt   <= '0;
            state <= ST_STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce channels (A and B) sharing one clock and reset.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  input_debouncer_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_chan_a (
    .clk (clk),
    .rst (rst),
    .raw (a_raw),
    .q   (a),
    .rise(a_rise),
    .fall(a_fall)
  );

  input_debouncer_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_chan_b (
    .clk (clk),
    .rst (rst),
    .raw (b_raw),
    .q   (b),
    .rise(b_rise),
    .fall(b_fall)
  );

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: INPUT_DEBOUNCER

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops per channel (legal range 2..4).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive disagreeing synchronized samples required to update an output (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-005 The block SHALL have port a_raw, input, 1 bit: asynchronous, bouncy channel-A input.
REQ-006 The block SHALL have port b_raw, input, 1 bit: asynchronous, bouncy channel-B input.
REQ-007 The block SHALL have port a, output, 1 bit: debounced channel A, registered, driving gate input a.
REQ-008 The block SHALL have port b, output, 1 bit: debounced channel B, registered, driving gate input b.
REQ-009 The block SHALL have ports a_rise, a_fall, b_rise and b_fall, each output, 1 bit: single-cycle edge strobes for the debounced outputs.

Function
REQ-010 Each channel SHALL pass its raw input through a chain of SYNC_STAGES flops; the synchronized value "s" is the last flop of the chain.
REQ-011 Each channel SHALL run a 2-state FSM, STABLE and COUNT, with a counter of width $clog2(STABLE_CYCLES+1).
REQ-012 In STABLE, when s equals the output, the counter SHALL hold 0.
REQ-013 In STABLE, when s differs from the output, the FSM SHALL go to COUNT with counter = 1; if STABLE_CYCLES = 1, it SHALL instead toggle the output and stay in STABLE.
REQ-014 In COUNT, when s equals the output (bounce), the FSM SHALL return to STABLE with counter = 0 and the output unchanged.
REQ-015 In COUNT, when s differs from the output and counter < STABLE_CYCLES-1, the counter SHALL increment.
REQ-016 In COUNT, when s differs from the output and counter = STABLE_CYCLES-1, the block SHALL toggle the output, clear the counter and go to STABLE.
REQ-017 Latency from the first edge that samples a stable new raw value to the output change SHALL be exactly SYNC_STAGES+STABLE_CYCLES clock edges (6 with the defaults).
REQ-018 The rise strobe SHALL be high for exactly one cycle, in the first cycle the output reads 1 after a 0->1 toggle; the fall strobe likewise for a 1->0 toggle.
REQ-019 Rise and fall strobes of the same channel SHALL never be high together.
REQ-020 Channels A and B SHALL be fully independent; simultaneous toggles on both channels SHALL both be reported in the same cycle.
REQ-021 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-022 A pulse shorter than STABLE_CYCLES synchronized cycles SHALL produce no output change and no strobe.

Reset
REQ-023 While rst = 1 at a clk edge, all synchronizer flops, a, b, counters and all strobes SHALL be 0 and the FSMs SHALL be in STABLE.
REQ-024 A reset asserted mid-count SHALL discard the count.
REQ-025 A raw input held at 1 through reset release SHALL reach the output SHALL+STABLE_CYCLES edges after the first edge with rst = 0, i.e. exactly SYNC_STAGES+STABLE_CYCLES edges after it, with a rise strobe.
REQ-026 No strobe SHALL be generated by reset itself.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (STABLE = 1'b0, COUNT = 1'b1) and the default SYNC_STAGES and STABLE_CYCLES constants.
REQ-028 The per-channel logic (synchronizer, FSM, counter, strobes) SHALL be one sub-module, DEBOUNCE_CHANNEL, instantiated twice.
REQ-029 The top level SHALL contain only the two instances and port wiring.

Verification
REQ-030 Reset, then a_raw 0->1 held, defaults -> a = 1 exactly 6 edges later; a_rise high for exactly one cycle; b and the B strobes stay 0.
REQ-031 b_raw glitch of 3 cycles high, defaults -> b stays 0, b_rise never asserts; counter returns to 0.
REQ-032 a_raw bouncing 1,0,1,1,0 then held 1 -> a rises only 6 edges after the final 0->1 transition.
REQ-033 a_raw and b_raw rise on the same edge -> a and b rise on the same cycle, a_rise and b_rise coincide.
REQ-034 a_raw high for 4 cycles, then rst pulsed for 1 cycle while a_raw stays high -> a = 0 during reset; a rises 6 edges after the first edge with rst = 0; no fall strobe.
REQ-035 With STABLE_CYCLES = 1, a_raw 1->0 after settling -> a falls 3 edges later with a single a_fall pulse.
